// File: rtl/fp_int_class_cvt.sv
// FP32 classify (FCLASS.S) and int32 -> FP32 conversion (FCVT.S.W / FCVT.S.WU).
// Single-cycle registered datapath with valid strobe and inexact flag.
module fp_int_class_cvt #(
    parameter int unsigned FLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid_in,
    input  logic [1:0]      op,
    input  logic [FLEN-1:0] rs1,
    input  logic [2:0]      rm,
    output logic [FLEN-1:0] result,
    output logic            valid_out,
    output logic            nx
);

    typedef enum logic [1:0] {
        OpClass = 2'd0,
        OpCvtW  = 2'd1,
        OpCvtWu = 2'd2,
        OpRsvd  = 2'd3
    } op_e;

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;

    op_e op_sel;
    assign op_sel = op_e'(op);

    // ---------------------------------------------------------------
    // Classification
    // ---------------------------------------------------------------
    logic        cls_sign;
    logic [7:0]  cls_exp;
    logic [22:0] cls_frac;
    logic        exp_max;
    logic        exp_zero;
    logic        frac_zero;
    logic [9:0]  class_mask;

    assign cls_sign  = rs1[31];
    assign cls_exp   = rs1[30:23];
    assign cls_frac  = rs1[22:0];
    assign exp_max   = (cls_exp == 8'hff);
    assign exp_zero  = (cls_exp == 8'h00);
    assign frac_zero = (cls_frac == 23'd0);

    always_comb begin
        class_mask = '0;
        if (exp_max) begin
            if (frac_zero) begin
                class_mask[cls_sign ? 0 : 7] = 1'b1;
            end else if (cls_frac[22]) begin
                class_mask[9] = 1'b1;
            end else begin
                class_mask[8] = 1'b1;
            end
        end else if (exp_zero) begin
            if (frac_zero) begin
                class_mask[cls_sign ? 3 : 4] = 1'b1;
            end else begin
                class_mask[cls_sign ? 2 : 5] = 1'b1;
            end
        end else begin
            class_mask[cls_sign ? 1 : 6] = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Integer to FP32 conversion
    // ---------------------------------------------------------------
    logic        cvt_sign;
    logic [31:0] cvt_mag;
    logic [4:0]  lzc;
    logic [31:0] norm;
    logic [7:0]  cvt_exp;
    logic        guard;
    logic        sticky;
    logic        round_inc;
    logic [30:0] cvt_rounded;
    logic [31:0] cvt_result;
    logic        cvt_nx;

    assign cvt_sign = (op_sel == OpCvtW) & rs1[31];
    // Two's-complement negate keeps 0x80000000 as magnitude 2^31.
    assign cvt_mag  = cvt_sign ? (~rs1[31:0] + 32'd1) : rs1[31:0];

    // Highest set bit wins since the loop scans upward.
    always_comb begin
        lzc = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (cvt_mag[i]) begin
                lzc = 5'(31 - i);
            end
        end
    end

    assign norm    = cvt_mag << lzc;
    assign cvt_exp = 8'd158 - {3'b000, lzc};
    assign guard   = norm[7];
    assign sticky  = |norm[6:0];

    always_comb begin
        round_inc = 1'b0;
        unique case (rm)
            RmRtz:   round_inc = 1'b0;
            RmRdn:   round_inc = (guard | sticky) & cvt_sign;
            RmRup:   round_inc = (guard | sticky) & ~cvt_sign;
            RmRmm:   round_inc = guard;
            RmRne:   round_inc = guard & (sticky | norm[8]);
            default: round_inc = guard & (sticky | norm[8]);
        endcase
    end

    // Fraction carry-out ripples into the exponent, covering mantissa overflow.
    assign cvt_rounded = {cvt_exp, norm[30:8]} + {30'd0, round_inc};

    // norm[31] is clear only for a zero operand.
    assign cvt_result = norm[31] ? {cvt_sign, cvt_rounded} : 32'd0;
    assign cvt_nx     = guard | sticky;

    // ---------------------------------------------------------------
    // Result select and output register
    // ---------------------------------------------------------------
    logic [FLEN-1:0] result_d, result_q;
    logic            nx_d, nx_q;
    logic            valid_q;

    always_comb begin
        result_d = '0;
        nx_d     = 1'b0;
        unique case (op_sel)
            OpClass: begin
                result_d = FLEN'({22'd0, class_mask});
                nx_d     = 1'b0;
            end
            OpCvtW, OpCvtWu: begin
                result_d = FLEN'(cvt_result);
                nx_d     = cvt_nx;
            end
            OpRsvd: begin
                result_d = '0;
                nx_d     = 1'b0;
            end
            default: begin
                result_d = '0;
                nx_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            result_q <= '0;
            nx_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                result_q <= result_d;
                nx_q     <= nx_d;
            end
        end
    end

    assign result    = result_q;
    assign nx        = nx_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_fp_int_class_cvt.sv
// Bench for fp_int_class_cvt: arithmetic reference model checked every cycle,
// plus directed vectors carrying hand-computed expected values.
module tb_fp_int_class_cvt;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_in;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [2:0]  rm;
    logic [31:0] result;
    logic        valid_out;
    logic        nx;

    fp_int_class_cvt #(.FLEN(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in),
        .op        (op),
        .rs1       (rs1),
        .rm        (rm),
        .result    (result),
        .valid_out (valid_out),
        .nx        (nx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed expectation attached to the request currently driven.
    logic        lit_on  = 1'b0;
    logic [31:0] lit_res = '0;
    logic        lit_nx  = 1'b0;
    logic        lit_vo  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_class(input logic [31:0] x);
        logic [31:0] a;
        logic        neg;
        a   = x & 32'h7fffffff;
        neg = x[31];
        if (a == 32'h0)             return neg ? 32'h008 : 32'h010;
        else if (a < 32'h00800000)  return neg ? 32'h004 : 32'h020;
        else if (a < 32'h7f800000)  return neg ? 32'h002 : 32'h040;
        else if (a == 32'h7f800000) return neg ? 32'h001 : 32'h080;
        else if (a >= 32'h7fc00000) return 32'h200;
        else                        return 32'h100;
    endfunction

    // Round the exact magnitude to 24 significant bits by comparing the
    // discarded remainder against half an ulp.
    function automatic void model_cvt(input logic [31:0] x, input bit is_signed,
                                      input logic [2:0] mode,
                                      output logic [31:0] r, output logic n);
        bit          s;
        longint      mag, q, rem, half;
        int          e, sh;
        bit          inc;
        logic [7:0]  be;
        s   = is_signed && x[31];
        mag = s ? (64'sh1_0000_0000 - longint'(x)) : longint'(x);
        if (mag == 0) begin
            r = 32'h0;
            n = 1'b0;
            return;
        end
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = mag << (23 - e); rem = 0; half = 1;
        end else begin
            sh = e - 23; q = mag >> sh; rem = mag - (q << sh); half = longint'(1) << (sh - 1);
        end
        case (mode)
            3'd1:    inc = 1'b0;
            3'd2:    inc = (rem != 0) && s;
            3'd3:    inc = (rem != 0) && !s;
            3'd4:    inc = (rem != 0) && (rem >= half);
            default: inc = (rem != 0) && ((rem > half) || (rem == half && q[0]));
        endcase
        q = q + longint'(inc);
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e++;
        end
        be = 8'(e + 127);
        r  = {s, be, q[22:0]};
        n  = (rem != 0);
    endfunction

    logic [31:0] m_res = '0;
    logic        m_vo  = 1'b0;
    logic        m_nx  = 1'b0;

    always @(posedge clk) begin : compare
        logic [31:0] r;
        logic        n;
        logic        c_on, c_nx, c_vo;
        logic [31:0] c_res;
        c_on = lit_on; c_res = lit_res; c_nx = lit_nx; c_vo = lit_vo;
        if (resetn) begin
            m_res = '0; m_vo = 1'b0; m_nx = 1'b0;
        end else begin
            m_vo = valid_in;
            if (valid_in) begin
                case (op)
                    2'd0:    begin r = model_class(rs1); n = 1'b0; end
                    2'd1:    model_cvt(rs1, 1'b1, rm, r, n);
                    2'd2:    model_cvt(rs1, 1'b0, rm, r, n);
                    default: begin r = '0; n = 1'b0; end
                endcase
                m_res = r; m_nx = n;
            end
        end
        #1;
        check("model result",    result,           m_res);
        check("model valid_out", 32'(valid_out),   32'(m_vo));
        check("model nx",        32'(nx),          32'(m_nx));
        if (c_on) begin
            check("vector result",    result,         c_res);
            check("vector valid_out", 32'(valid_out), 32'(c_vo));
            check("vector nx",        32'(nx),        32'(c_nx));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [2:0] r,
                         input logic [31:0] er, input logic enx);
        @(negedge clk);
        valid_in = 1'b1; op = o; rs1 = a; rm = r;
        lit_on = 1'b1; lit_res = er; lit_nx = enx; lit_vo = 1'b1;
    endtask

    task automatic issue_model(input logic [1:0] o, input logic [31:0] a, input logic [2:0] r);
        @(negedge clk);
        valid_in = 1'b1; op = o; rs1 = a; rm = r; lit_on = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            valid_in = 1'b0; lit_on = 1'b0;
        end
    endtask

    initial begin
        resetn = 1'b1; valid_in = 1'b0; op = 2'd0; rs1 = '0; rm = 3'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        idle(2);

        // FCLASS sweep
        issue(2'd0, 32'hff800000, 3'd0, 32'h001, 1'b0);
        issue(2'd0, 32'h80000000, 3'd0, 32'h008, 1'b0);
        issue(2'd0, 32'h00000001, 3'd0, 32'h020, 1'b0);
        issue(2'd0, 32'h3f800000, 3'd0, 32'h040, 1'b0);
        issue(2'd0, 32'h7f800001, 3'd0, 32'h100, 1'b0);
        issue(2'd0, 32'h7fc00000, 3'd0, 32'h200, 1'b0);
        issue(2'd0, 32'hffc00000, 3'd0, 32'h200, 1'b0);
        issue(2'd0, 32'h00000000, 3'd0, 32'h010, 1'b0);
        issue(2'd0, 32'h807fffff, 3'd0, 32'h004, 1'b0);
        issue(2'd0, 32'hc0000000, 3'd0, 32'h002, 1'b0);
        issue(2'd0, 32'h7f800000, 3'd0, 32'h080, 1'b0);
        idle(1);

        // FCVT.S.W exact
        issue(2'd1, 32'h00000000, 3'd0, 32'h00000000, 1'b0);
        issue(2'd1, 32'h00000001, 3'd0, 32'h3f800000, 1'b0);
        issue(2'd1, 32'hffffffff, 3'd0, 32'hbf800000, 1'b0);
        issue(2'd1, 32'h80000000, 3'd0, 32'hcf000000, 1'b0);
        // FCVT.S.W rounding of 0x7FFFFFFF
        issue(2'd1, 32'h7fffffff, 3'd0, 32'h4f000000, 1'b1);
        issue(2'd1, 32'h7fffffff, 3'd1, 32'h4effffff, 1'b1);
        issue(2'd1, 32'h7fffffff, 3'd3, 32'h4f000000, 1'b1);
        issue(2'd1, 32'h7fffffff, 3'd2, 32'h4effffff, 1'b1);
        // Negative operand: RDN rounds magnitude up, RUP truncates
        issue(2'd1, 32'h80000001, 3'd2, 32'hcf000000, 1'b1);
        issue(2'd1, 32'h80000001, 3'd3, 32'hceffffff, 1'b1);
        idle(2);

        // FCVT.S.WU rounding
        issue(2'd2, 32'hffffffff, 3'd0, 32'h4f800000, 1'b1);
        issue(2'd2, 32'hffffffff, 3'd1, 32'h4f7fffff, 1'b1);
        issue(2'd2, 32'h01000001, 3'd0, 32'h4b800000, 1'b1);
        issue(2'd2, 32'h01000001, 3'd3, 32'h4b800001, 1'b1);
        issue(2'd2, 32'h01000001, 3'd4, 32'h4b800001, 1'b1);
        issue(2'd2, 32'h01000003, 3'd0, 32'h4b800002, 1'b1);
        issue(2'd2, 32'h01000001, 3'd7, 32'h4b800000, 1'b1);
        issue(2'd2, 32'h80000000, 3'd0, 32'h4f000000, 1'b0);
        idle(1);

        // Back-to-back mixed ops, some checked only by the model
        issue(2'd0, 32'h3f800000, 3'd0, 32'h040, 1'b0);
        issue(2'd1, 32'hffffffff, 3'd0, 32'hbf800000, 1'b0);
        issue(2'd2, 32'hffffffff, 3'd0, 32'h4f800000, 1'b1);
        issue(2'd3, 32'h12345678, 3'd0, 32'h0, 1'b0);
        issue_model(2'd1, 32'h00ffffff, 3'd0);
        issue_model(2'd1, 32'hfe000003, 3'd4);
        issue_model(2'd2, 32'h12345678, 3'd2);
        issue_model(2'd0, 32'h00400000, 3'd0);
        issue_model(2'd2, 32'hdeadbeef, 3'd3);
        issue_model(2'd1, 32'h87654321, 3'd0);
        idle(3);

        // Reset wins over a concurrent request; nx set beforehand
        issue(2'd2, 32'hffffffff, 3'd0, 32'h4f800000, 1'b1);
        @(negedge clk);
        resetn = 1'b1; valid_in = 1'b1; op = 2'd1; rs1 = 32'h00000001; rm = 3'd0;
        lit_on = 1'b1; lit_res = 32'h0; lit_nx = 1'b0; lit_vo = 1'b0;
        @(negedge clk);
        resetn = 1'b0; valid_in = 1'b0; lit_on = 1'b0;
        idle(1);

        // Reserved op after a nonzero result
        issue(2'd1, 32'h00000001, 3'd0, 32'h3f800000, 1'b0);
        issue(2'd3, 32'hffffffff, 3'd0, 32'h0, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
